// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop add two WIDTH-bit
// operands LSB first behind a start/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: start_i is accepted on a rising edge while in IDLE or DONE;
  // done_o pulses for exactly one cycle when sum_o/cout_o take a new result.
  typedef struct packed {
    state_t        state;
    logic [CW-1:0] cnt;
    logic          carry;
  } dbg_t;

  state_t         state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] sum_shift;
  dbg_t             dbg;

  assign s_bit     = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next    = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign sum_shift = {s_bit, sreg_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sreg_d  = sreg_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          sreg_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sreg_d  = sum_shift;
        carry_d = c_next;
        if (cnt_q == LAST) begin
          // Last bit: publish the full result and park the counter at zero.
          sum_d   = sum_shift;
          cout_d  = c_next;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sreg_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sreg_q  <= sreg_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

  assign dbg.state = state_q;
  assign dbg.cnt   = cnt_q;
  assign dbg.carry = carry_q;

  a_busy_done_excl: assert property (@(posedge clk_i) disable iff (rst_i)
    !(busy_q && done_q));
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    dbg.cnt <= LAST);
  a_done_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
    done_q |=> !done_q);
  a_state_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    dbg.state != 2'd3);

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed scenarios on an 8-bit instance, an
// exhaustive sweep on a 4-bit instance, and randomized back-to-back traffic.
module tb_serial_adder;

  logic clk;
  logic rst;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8),
    .cin_i(cin8), .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .a_i(a4), .b_i(b4),
    .cin_i(cin4), .busy_o(busy4), .done_o(done4), .sum_o(sum4), .cout_o(cout4)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: called at a negedge; returns at the negedge where done is seen
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         output int lat, output int busy_cnt, output bit early);
    logic [8:0] prev;
    prev = {cout8, sum8};
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    lat = -1; busy_cnt = 0; early = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 0) start8 = 1'b0;
      if (done8) begin
        lat = i;
        break;
      end
      if (busy8) busy_cnt++;
      if ({cout8, sum8} !== prev) early = 1'b1;
    end
  endtask

  task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic c,
                         output int lat);
    start4 = 1'b1; a4 = a; b4 = b; cin4 = c;
    lat = -1;
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) start4 = 1'b0;
      if (done4) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start8 = 1'b1; a8 = 8'h3C; b8 = 8'h05; cin8 = 1'b1;
    start4 = 1'b1; a4 = 4'hF; b4 = 4'h1; cin4 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done8); end
    checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h want 00", sum8); end
    checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout8); end
    checks++; if ({busy4, done4, cout4, sum4} !== 7'd0) begin
      errors++; $display("FAIL reset_w4: got %b want 0", {busy4, done4, cout4, sum4});
    end
    rst = 1'b0; start8 = 1'b0; start4 = 1'b0;
    @(negedge clk);
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_no_start: busy got %b want 0", busy8); end
  endtask

  task automatic test_basic();
    int lat, bc;
    bit early;
    run_op8(8'h3C, 8'h05, 1'b0, lat, bc, early);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
    checks++; if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
    checks++; if (early) begin errors++; $display("FAIL basic_partial: result changed before done"); end
    checks++; if (sum8 !== 8'h41) begin errors++; $display("FAIL basic_sum: got %h want 41", sum8); end
    checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b want 0", cout8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", busy8); end
    @(negedge clk);
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done8); end
    checks++; if (sum8 !== 8'h41) begin errors++; $display("FAIL basic_hold: got %h want 41", sum8); end
  endtask

  task automatic test_carry_chain();
    int lat, bc;
    bit early;
    run_op8(8'hFF, 8'h01, 1'b0, lat, bc, early);
    checks++; if ({cout8, sum8} !== 9'h100) begin
      errors++; $display("FAIL carry_ff_01: got %h want 100", {cout8, sum8});
    end
    @(negedge clk);
    run_op8(8'hFF, 8'hFF, 1'b1, lat, bc, early);
    checks++; if ({cout8, sum8} !== 9'h1FF) begin
      errors++; $display("FAIL carry_ff_ff_1: got %h want 1ff", {cout8, sum8});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int done_seen, busy_seen;
    done_seen = 0; busy_seen = 0;
    start8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) start8 = 1'b0;
      if (done8) done_seen++;
      if (i == 3) rst = 1'b1;
    end
    @(negedge clk);
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy8); end
    checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL midrst_sum: got %h want 00", sum8); end
    checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL midrst_cout: got %b want 0", cout8); end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) done_seen++;
      if (busy8) busy_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_seen); end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL midrst_no_busy: got %0d cycles want 0", busy_seen); end
  endtask

  task automatic test_start_while_busy();
    int lat;
    lat = -1;
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 0) start8 = 1'b0;
      if (i == 2) begin start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; end
      if (i == 3) start8 = 1'b0;
      if (done8) begin
        lat = i;
        break;
      end
    end
    checks++; if (lat !== 8) begin errors++; $display("FAIL busy_start_latency: got %0d want 8", lat); end
    checks++; if ({cout8, sum8} !== 9'h030) begin
      errors++; $display("FAIL busy_start_ignored: got %h want 030", {cout8, sum8});
    end
    // back-to-back: start held during DONE
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy8); end
    checks++; if (sum8 !== 8'h30) begin errors++; $display("FAIL b2b_hold_prev: got %h want 30", sum8); end
    lat = -1;
    for (int i = 1; i < 24; i++) begin
      @(negedge clk);
      if (done8) begin
        lat = i;
        break;
      end
    end
    checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_latency: got %0d want 8", lat); end
    checks++; if ({cout8, sum8} !== 9'h003) begin
      errors++; $display("FAIL b2b_sum: got %h want 003", {cout8, sum8});
    end
    @(negedge clk);
  endtask

  task automatic test_exhaustive4();
    int lat;
    logic [4:0] exp;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          exp = 5'(a + b + c);
          run_op4(4'(a), 4'(b), 1'(c), lat);
          checks++; if ({cout4, sum4} !== exp) begin
            errors++; $display("FAIL exh4_sum a=%0d b=%0d c=%0d: got %h want %h", a, b, c, {cout4, sum4}, exp);
          end
          checks++; if (lat !== 4) begin
            errors++; $display("FAIL exh4_latency a=%0d b=%0d c=%0d: got %0d want 4", a, b, c, lat);
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random8();
    logic [8:0] exp_q[$];
    logic [8:0] exp;
    logic [7:0] a, b;
    logic       c;
    int lat, bc;
    bit early;
    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      c = 1'($urandom_range(0, 1));
      exp_q.push_back(9'({1'b0, a}) + 9'({1'b0, b}) + 9'(c));
      run_op8(a, b, c, lat, bc, early);
      exp = exp_q.pop_front();
      checks++; if ({cout8, sum8} !== exp || lat !== 8) begin
        errors++; $display("FAIL rand_op%0d a=%h b=%h c=%b: got %h lat %0d want %h lat 8", n, a, b, c, {cout8, sum8}, lat, exp);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_reset_mid();
    test_start_while_busy();
    test_exhaustive4();
    test_random8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
